rr_sched64: RTL and testbench
=============================

Name: rr_sched64

Overview:
- Round-robin scheduler that shares one 6-bit select resource among 64 requesters.
- Its registered gnt_idx drives the A input of the 6-to-64 decoder. gnt_valid drives the decoder en. gnt_onehot is a registered copy of the same decode for local use.
- Grants are held until the requester drops its request or a hold limit expires. A one-cycle gap follows every grant.

Parameters:
- MAX_HOLD, 16, maximum cycles one grant may stay asserted; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  scheduler enable; low blocks new grants and ends the current grant.
- req  in  64  request vector; bit i = requester i wants the resource; level-sensitive.
- gnt_valid  out  1  a grant is active (registered).
- gnt_idx  out  6  index of the granted requester (registered).
- gnt_onehot  out  64  one-hot grant; equals 1<<gnt_idx when gnt_valid, else all zero (registered).
- hold_cnt  out  CNT_W  cycles elapsed in the current grant, 0-based (registered).

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state=IDLE, ptr=0.
  - gnt_valid=0, gnt_idx=0, gnt_onehot=0, hold_cnt=0.
  - Reset dominates all other inputs, including mid-grant; the grant drops on the next edge.
- States:
  - IDLE: no grant active.
  - GRANT: one requester holds the resource.
  - GAP: mandatory one-cycle release cycle.
- Winner selection, evaluated combinationally in IDLE:
  - Winner = first set bit of req scanning ptr, ptr+1, ... 63, 0, ... ptr-1, with modulo-64 wrap.
  - Only req and ptr are used.
- IDLE:
  - If en=1 and req!=0: next edge sets state=GRANT, gnt_valid=1, gnt_idx=winner, gnt_onehot=1<<winner, hold_cnt=0.
  - Latency: req sampled at edge t gives outputs valid after edge t (one cycle).
  - Otherwise remain in IDLE with all outputs 0.
- GRANT, terminate condition:
  - The grant terminates when en=0, or req[gnt_idx]=0, or hold_cnt==MAX_HOLD-1.
  - On terminate, next edge sets state=GAP, gnt_valid=0, gnt_onehot=0, hold_cnt=0, ptr=gnt_idx+1 (63 wraps to 0).
  - gnt_idx keeps its last value in GAP/IDLE; it is don't-care when gnt_valid=0.
  - Otherwise hold_cnt increments and gnt_idx is unchanged.
  - With MAX_HOLD=1 every grant lasts exactly one cycle.
- GAP:
  - Outputs stay deasserted for exactly one cycle, then state=IDLE unconditionally.
  - Minimum spacing between consecutive grants is therefore 2 idle cycles.
  - Purpose: guarantee decoder outputs never switch between two live indices.
- Simultaneous events:
  - Other req bits changing during GRANT are ignored.
  - en=0 and timeout together count as a single terminate.
  - A requester that drops and re-raises within GAP competes normally in IDLE, from the updated ptr.
- Fairness:
  - Because ptr advances past each winner, every continuously requesting index is granted within 63 grants.
  - Worst-case wait ≤ 63*(MAX_HOLD+2) cycles.
- Invariants:
  - gnt_onehot has popcount ≤1 at all times.
  - gnt_valid==(gnt_onehot!=0).
  - hold_cnt<MAX_HOLD.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then single request: rst 1 for 2 cycles, then req=1<<5 held, en=1 -> gnt_valid=1, gnt_idx=5, gnt_onehot=0x20 one cycle after request. Drop req[5] -> gnt_valid=0 next edge. GAP then IDLE follow.
- Round-robin wrap: req=0x8000_0000_0000_0001 held, MAX_HOLD=4 -> grants to 0, then 63, then 0, each 4 cycles long. Two idle cycles separate each grant; ptr wraps 63->0.
- Timeout: req[10] held constantly, MAX_HOLD=16 -> gnt_valid high exactly 16 cycles with hold_cnt 0..15. Then GAP, IDLE, and a regrant of 10 (sole requester).
- Enable drop mid-grant: grant active on idx 40, en=0 at hold_cnt=3 -> gnt_valid=0 next edge. No new grant while en=0 despite req!=0.
- Reset mid-grant: grant on idx 7, assert rst for 1 cycle -> all outputs 0 next edge. After release the next winner is the lowest set index from ptr=0.
- Fairness sweep: req=all ones for 64 grants with MAX_HOLD=1 -> gnt_idx sequence 0,1,...,63,0. Check onehot popcount ≤1 every cycle.

Source files
------------

// File: rtl/rr_sched64.sv
// rr_sched64 -- round-robin scheduler sharing one 6-bit select among 64
// requesters.
//
// The registered grant index feeds the A input of an external 6-to-64
// decoder, and gnt_valid_o feeds its enable. A grant is held until its
// requester drops the request, the enable drops, or the hold limit expires.
// Every grant is followed by a mandatory one-cycle gap, so the decoder never
// switches directly from one live index to another.
//
// Parameters:
//   MAX_HOLD  maximum cycles one grant may stay asserted (1..255)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         synchronous reset, active-high
//   en_i          scheduler enable; low blocks new grants and ends the current one
//   req_i[63:0]   level-sensitive request vector
//   gnt_valid_o   a grant is active (registered)
//   gnt_idx_o     index of the granted requester (registered; stale when not valid)
//   gnt_onehot_o  1 << gnt_idx_o while valid, else zero (registered)
//   hold_cnt_o    cycles elapsed in the current grant, 0-based (registered)

module rr_sched64 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [63:0]      req_i,
    output logic             gnt_valid_o,
    output logic [5:0]       gnt_idx_o,
    output logic [63:0]      gnt_onehot_o,
    output logic [CNT_W-1:0] hold_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [5:0]       idx_q, idx_d;
    logic [63:0]      onehot_q, onehot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [63:0]      req_rot;
    logic [5:0]       win_off;
    logic [5:0]       winner;
    logic             hold_last;
    logic             terminate;

    // Rotate the request vector so that bit 0 corresponds to ptr_q; the lowest
    // set bit of the rotated vector is then the round-robin winner, offset
    // from ptr_q. The 6-bit add wraps modulo 64 for free.
    always_comb begin
        req_rot = 64'(({req_i, req_i} >> ptr_q));
        win_off = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 6'(i);
            end
        end
        winner = ptr_q + win_off;
    end

    assign hold_last = (cnt_q == CNT_W'(MAX_HOLD - 1));
    assign terminate = !en_i || !req_i[idx_q] || hold_last;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (en_i && (req_i != 64'd0)) begin
                    state_d  = GRANT;
                    valid_d  = 1'b1;
                    idx_d    = winner;
                    onehot_d = 64'd1 << winner;
                    cnt_d    = '0;
                end
            end
            GRANT: begin
                if (terminate) begin
                    // idx_q is deliberately left alone: it is don't-care while
                    // not valid and holding it keeps the decoder A input quiet.
                    state_d  = GAP;
                    valid_d  = 1'b0;
                    onehot_d = 64'd0;
                    cnt_d    = '0;
                    ptr_d    = idx_q + 6'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                valid_d  = 1'b0;
                onehot_d = 64'd0;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= 6'd0;
            valid_q  <= 1'b0;
            idx_q    <= 6'd0;
            onehot_q <= 64'd0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt_valid_o  = valid_q;
    assign gnt_idx_o    = idx_q;
    assign gnt_onehot_o = onehot_q;
    assign hold_cnt_o   = cnt_q;

endmodule

// File: tb/tb_rr_sched64.sv
// Bench for rr_sched64. Three instances (MAX_HOLD = 16, 4 and 1) share one
// input stream; each is tracked every cycle by a behavioural model, while the
// directed sequences check hand-derived expectations on one instance each.

module tb_rr_sched64;

    logic        clk;
    logic        rst;
    logic        en;
    logic [63:0] req;

    logic        v16, v4, v1;
    logic [5:0]  i16, i4, i1;
    logic [63:0] oh16, oh4, oh1;
    logic [7:0]  c16, c4, c1;

    int n_cmp  = 0;
    int n_fail = 0;

    rr_sched64 #(.MAX_HOLD(16), .CNT_W(8)) dut16 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req),
        .gnt_valid_o(v16), .gnt_idx_o(i16), .gnt_onehot_o(oh16), .hold_cnt_o(c16)
    );
    rr_sched64 #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req),
        .gnt_valid_o(v4), .gnt_idx_o(i4), .gnt_onehot_o(oh4), .hold_cnt_o(c4)
    );
    rr_sched64 #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req),
        .gnt_valid_o(v1), .gnt_idx_o(i1), .gnt_onehot_o(oh1), .hold_cnt_o(c1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (%0d compared)", n_cmp);
        $fatal(1, "watchdog");
    end

    // Behavioural model: phase 0 = nothing happening, 1 = granted, 2 = release gap.
    typedef struct {
        int phase;
        int ptr;
        bit valid;
        int idx;
        int cnt;
    } mdl_t;

    mdl_t m16, m4, m1;

    function automatic mdl_t mstep(mdl_t m, bit r, bit e, logic [63:0] q, int mh);
        mdl_t n = m;
        if (r) begin
            n.phase = 0; n.ptr = 0; n.valid = 0; n.idx = 0; n.cnt = 0;
            return n;
        end
        if (m.phase == 0) begin
            if (e && q != 64'd0) begin
                for (int k = 0; k < 64; k++) begin
                    int j;
                    j = (m.ptr + k) % 64;
                    if (q[j]) begin
                        n.phase = 1; n.valid = 1; n.idx = j; n.cnt = 0;
                        break;
                    end
                end
            end
        end else if (m.phase == 1) begin
            if (!e || !q[m.idx] || (m.cnt + 1 >= mh)) begin
                n.phase = 2; n.valid = 0; n.cnt = 0;
                n.ptr = (m.idx + 1) % 64;
            end else begin
                n.cnt = m.cnt + 1;
            end
        end else begin
            n.phase = 0;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_one(input string nm, input mdl_t m, input logic v, input logic [5:0] ix,
                           input logic [63:0] oh, input logic [7:0] c);
        logic [63:0] exp_oh;
        exp_oh = m.valid ? (64'd1 << m.idx) : 64'd0;
        chk({nm, "_valid"}, 64'(v), 64'(m.valid));
        chk({nm, "_onehot"}, oh, exp_oh);
        chk({nm, "_cnt"}, 64'(c), 64'(m.cnt));
        if (m.valid) chk({nm, "_idx"}, 64'(ix), 64'(m.idx));
        chk({nm, "_popcnt_le1"}, 64'($countones(oh) <= 1), 64'd1);
    endtask

    task automatic cyc(input logic r, input logic e, input logic [63:0] q);
        rst = r; en = e; req = q;
        @(posedge clk);
        m16 = mstep(m16, r, e, q, 16);
        m4  = mstep(m4,  r, e, q, 4);
        m1  = mstep(m1,  r, e, q, 1);
        #1;
        chk_one("m16", m16, v16, i16, oh16, c16);
        chk_one("m4",  m4,  v4,  i4,  oh4,  c4);
        chk_one("m1",  m1,  v1,  i1,  oh1,  c1);
    endtask

    // Direct expectation against the MAX_HOLD=16 / 4 / 1 instance selected by sel.
    task automatic expect_g(input string nm, input int sel, input bit ev, input int eidx, input int ecnt);
        logic v; logic [5:0] ix; logic [63:0] oh; logic [7:0] c;
        if (sel == 16) begin v = v16; ix = i16; oh = oh16; c = c16; end
        else if (sel == 4) begin v = v4; ix = i4; oh = oh4; c = c4; end
        else begin v = v1; ix = i1; oh = oh1; c = c1; end
        chk({nm, "_valid"}, 64'(v), 64'(ev));
        chk({nm, "_cnt"}, 64'(c), 64'(ecnt));
        chk({nm, "_onehot"}, oh, ev ? (64'd1 << eidx) : 64'd0);
        if (ev) chk({nm, "_idx"}, 64'(ix), 64'(eidx));
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        logic [63:0] req;
        bit          ev;
        int          eidx;
        int          ecnt;
    } vec_t;

    vec_t tv[12];

    initial begin
        logic [63:0] w;
        logic [63:0] cur;
        rst = 1'b1; en = 1'b0; req = 64'd0;
        m16 = '{0, 0, 0, 0, 0}; m4 = m16; m1 = m16;

        // Reset, single request on 5, drop, gap, regrant, other bits ignored,
        // enable low, then a regrant that honours the advanced pointer.
        tv[0]  = '{1'b1, 1'b0, 64'd0,                 1'b0, 0, 0};
        tv[1]  = '{1'b1, 1'b1, 64'h20,                1'b0, 0, 0};
        tv[2]  = '{1'b0, 1'b1, 64'h20,                1'b1, 5, 0};
        tv[3]  = '{1'b0, 1'b1, 64'h20,                1'b1, 5, 1};
        tv[4]  = '{1'b0, 1'b1, 64'h0,                 1'b0, 0, 0};
        tv[5]  = '{1'b0, 1'b1, 64'h20,                1'b0, 0, 0};
        tv[6]  = '{1'b0, 1'b1, 64'h20,                1'b1, 5, 0};
        tv[7]  = '{1'b0, 1'b1, 64'h220,               1'b1, 5, 1};
        tv[8]  = '{1'b0, 1'b0, 64'h220,               1'b0, 0, 0};
        tv[9]  = '{1'b0, 1'b0, 64'h220,               1'b0, 0, 0};
        tv[10] = '{1'b0, 1'b0, 64'h220,               1'b0, 0, 0};
        tv[11] = '{1'b0, 1'b1, 64'h220,               1'b1, 9, 0};
        for (int i = 0; i < 12; i++) begin
            cyc(tv[i].rst, tv[i].en, tv[i].req);
            expect_g($sformatf("vec%0d", i), 16, tv[i].ev, tv[i].eidx, tv[i].ecnt);
        end

        // Round-robin wrap with MAX_HOLD=4: 0, 63, 0 with two dead cycles between.
        cyc(1'b1, 1'b0, 64'd0);
        w = 64'h8000_0000_0000_0001;
        for (int k = 0; k < 18; k++) begin
            int pos;
            pos = k % 6;
            cyc(1'b0, 1'b1, w);
            expect_g($sformatf("wrap%0d", k), 4, pos < 4, ((k / 6) % 2) ? 63 : 0, (pos < 4) ? pos : 0);
        end

        // Timeout with MAX_HOLD=16 on a sole requester 10.
        cyc(1'b1, 1'b0, 64'd0);
        for (int k = 0; k < 19; k++) begin
            int pos;
            pos = k % 18;
            cyc(1'b0, 1'b1, 64'd1 << 10);
            expect_g($sformatf("tmo%0d", k), 16, pos < 16, 10, (pos < 16) ? pos : 0);
        end

        // Enable drop at hold_cnt=3 on idx 40; no grant while en is low.
        cyc(1'b1, 1'b0, 64'd0);
        cyc(1'b0, 1'b1, 64'd1 << 40);
        expect_g("endrop_g", 16, 1'b1, 40, 0);
        for (int k = 1; k <= 3; k++) cyc(1'b0, 1'b1, 64'd1 << 40);
        expect_g("endrop_c3", 16, 1'b1, 40, 3);
        cyc(1'b0, 1'b0, 64'd1 << 40);
        expect_g("endrop_off", 16, 1'b0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, (64'd1 << 40) | 64'd2);
            expect_g($sformatf("endrop_blk%0d", k), 16, 1'b0, 0, 0);
        end
        cyc(1'b0, 1'b1, (64'd1 << 40) | 64'd2);
        expect_g("endrop_next", 16, 1'b1, 1, 0);

        // Reset mid-grant: pointer must return to 0 (winner 3, not 60).
        cyc(1'b1, 1'b0, 64'd0);
        cyc(1'b0, 1'b1, 64'd1 << 3);
        expect_g("rmid_g3", 16, 1'b1, 3, 0);
        cyc(1'b0, 1'b1, 64'd1 << 7);
        cyc(1'b0, 1'b1, 64'd1 << 7);
        cyc(1'b0, 1'b1, 64'd1 << 7);
        expect_g("rmid_g7", 16, 1'b1, 7, 0);
        cyc(1'b0, 1'b1, 64'd1 << 7);
        expect_g("rmid_g7c1", 16, 1'b1, 7, 1);
        cyc(1'b1, 1'b1, 64'd1 << 7);
        expect_g("rmid_rst", 16, 1'b0, 0, 0);
        chk("rmid_idx0", 64'(i16), 64'd0);
        cyc(1'b0, 1'b1, (64'd1 << 3) | (64'd1 << 60));
        expect_g("rmid_after", 16, 1'b1, 3, 0);

        // Fairness sweep with MAX_HOLD=1 and all requesters active.
        cyc(1'b1, 1'b0, 64'd0);
        for (int g = 0; g < 65; g++) begin
            cyc(1'b0, 1'b1, '1);
            expect_g($sformatf("fair%0d", g), 1, 1'b1, g % 64, 0);
            cyc(1'b0, 1'b1, '1);
            expect_g($sformatf("fair%0d_gap", g), 1, 1'b0, 0, 0);
            cyc(1'b0, 1'b1, '1);
            expect_g($sformatf("fair%0d_idle", g), 1, 1'b0, 0, 0);
        end

        // Randomized traffic against the model.
        cur = 64'd0;
        for (int k = 0; k < 3000; k++) begin
            bit r, e;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: cur = 64'd0;
                    1: cur = 64'd1 << $urandom_range(0, 63);
                    2: cur = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63))
                             | (64'd1 << $urandom_range(0, 63));
                    default: cur = {$urandom, $urandom};
                endcase
            end
            cyc(r, e, cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
